// File: rtl/commit_unit.sv
// Retire stage behind the ROB commit port: AMT write, free-list return, store release.
// Optional retired-instruction counter enabled by defining COMMIT_INSTRET_EN.
package commit_pkg;
    localparam int ROB_W  = 6;
    localparam int PHYS_W = 7;

    typedef struct packed {
        logic              uses_rd;
        logic [4:0]        rd_arch;
        logic [PHYS_W-1:0] pd_new;
        logic [PHYS_W-1:0] pd_old;
        logic              is_store;
    } rob_entry_t;
endpackage

module commit_unit
    import commit_pkg::*;
#(
    parameter int ROB_W_P  = ROB_W,
    parameter int PHYS_W_P = PHYS_W,
    parameter int ARCH_W_P = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                commit_valid,
    output logic                commit_ready,
    input  rob_entry_t          commit_entry,
    input  logic [ROB_W_P-1:0]  commit_rob_idx,
    input  logic                flush_valid,
    output logic                amt_we,
    output logic [ARCH_W_P-1:0] amt_rd_arch,
    output logic [PHYS_W_P-1:0] amt_pd,
    output logic                free_valid,
    output logic [PHYS_W_P-1:0] free_pd,
    input  logic                free_ready,
    output logic                st_commit_valid,
    output logic [ROB_W_P-1:0]  st_commit_rob_idx,
    input  logic                st_commit_ack,
    output logic [63:0]         instret
);
    typedef enum logic {RUN, ST_WAIT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_fire;
    logic                 w_writer;
    logic                 r_amt_we;
    logic [ARCH_W_P-1:0]  r_amt_rd_arch;
    logic [PHYS_W_P-1:0]  r_amt_pd;
    logic                 r_free_valid;
    logic [PHYS_W_P-1:0]  r_free_pd;
    logic                 r_st_valid;
    logic [ROB_W_P-1:0]   r_st_idx;

    assign w_writer = commit_entry.uses_rd && (commit_entry.rd_arch != '0);
    assign w_fire   = commit_valid && commit_ready;

    // Flush wins over everything, including an ack arriving in the same cycle.
    always_comb begin
        commit_ready = 1'b0;
        w_state_nxt  = r_state;
        if (flush_valid) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (!commit_entry.is_store)
                        commit_ready = !r_free_valid || free_ready;
                    else if (commit_valid)
                        w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    commit_ready = st_commit_ack;
                    if (st_commit_ack)
                        w_state_nxt = RUN;
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_st_valid <= 1'b0;
            r_st_idx   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_st_valid <= (w_state_nxt == ST_WAIT);
            if (r_state == RUN && w_state_nxt == ST_WAIT)
                r_st_idx <= commit_rob_idx;
        end
    end

    // Free and AMT side effects belong to retired instructions, so flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amt_we      <= 1'b0;
            r_amt_rd_arch <= '0;
            r_amt_pd      <= '0;
            r_free_valid  <= 1'b0;
            r_free_pd     <= '0;
        end else begin
            r_amt_we <= w_fire && w_writer;
            if (w_fire && w_writer) begin
                r_amt_rd_arch <= commit_entry.rd_arch;
                r_amt_pd      <= commit_entry.pd_new;
                r_free_valid  <= 1'b1;
                r_free_pd     <= commit_entry.pd_old;
            end else if (r_free_valid && free_ready) begin
                r_free_valid  <= 1'b0;
            end
        end
    end

`ifdef COMMIT_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst)
            r_instret <= '0;
        else if (w_fire)
            r_instret <= r_instret + 64'd1;
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

    assign amt_we            = r_amt_we;
    assign amt_rd_arch       = r_amt_rd_arch;
    assign amt_pd            = r_amt_pd;
    assign free_valid        = r_free_valid;
    assign free_pd           = r_free_pd;
    assign st_commit_valid   = r_st_valid;
    assign st_commit_rob_idx = r_st_idx;
endmodule

// File: doc/commit_unit.md
# commit_unit

Retire stage directly downstream of the reorder buffer's commit port. It consumes one committed ROB entry per handshake and performs the architectural side effects:
- writes the architectural map table (AMT);
- returns the stale physical register `pd_old` to the free list;
- releases committed stores to the store buffer.

It also maintains the retired-instruction count and applies backpressure to the ROB whenever a side-effect consumer is busy.

## Interface
Parameters:
- `ROB_W_P`, default `ROB_W`: ROB index width.
- `PHYS_W_P`, default `PHYS_W`: physical register index width.
- `ARCH_W_P`, default 5: architectural register index width.

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `commit_valid`  in  1  ROB head is committable.
- `commit_ready`  out  1  unit accepts the head this cycle.
- `commit_entry`  in  `rob_entry_t`  committed entry. Fields used: `uses_rd`, `rd_arch`, `pd_new`, `pd_old`, `is_store`.
- `commit_rob_idx`  in  `ROB_W_P`  index of the committed entry.
- `flush_valid`  in  1  pipeline nuke (same signal that drives the ROB).
- `amt_we`  out  1  AMT write pulse.
- `amt_rd_arch`  out  `ARCH_W_P`  AMT write index.
- `amt_pd`  out  `PHYS_W_P`  AMT write data (`pd_new`).
- `free_valid`  out  1  a stale physical register is offered to the free list.
- `free_pd`  out  `PHYS_W_P`  the register being freed (`pd_old`).
- `free_ready`  in  1  free list accepts.
- `st_commit_valid`  out  1  store release request.
- `st_commit_rob_idx`  out  `ROB_W_P`  ROB index of the store being released.
- `st_commit_ack`  in  1  store buffer has marked the store committed.
- `instret`  out  64  retired-instruction count (`COMMIT_INSTRET_EN` only).

## Operation
- `commit_fire = commit_valid && commit_ready`.
- A "writer" is an entry with `uses_rd && rd_arch != 0`.
  - A writer causes one AMT write and one free-list push of `pd_old`.
  - A non-writer (including any `rd_arch == 0`) causes neither.

FSM states: RUN, ST_WAIT.
- RUN, non-store head:
  - `commit_ready = !free_valid || free_ready`, i.e. the free register is empty or draining this cycle.
- RUN, store head:
  - `commit_ready = 0`.
  - When `commit_valid` is high, the unit registers `st_commit_valid = 1` and `st_commit_rob_idx = commit_rob_idx`, and moves to ST_WAIT.
- ST_WAIT:
  - `commit_ready = st_commit_ack`.
  - On ack the store commits in that same cycle, `st_commit_valid` drops next cycle, and the FSM returns to RUN.
  - `st_commit_valid` and `st_commit_rob_idx` stay stable until ack.
- Free register:
  - Loaded on `commit_fire` of a writer.
  - Held until `free_valid && free_ready`.
  - A simultaneous drain and load is legal; the new value replaces the old one with no bubble.
- AMT:
  - `amt_we` is a registered one-cycle pulse.
  - It carries `rd_arch` and `pd_new` of the writer that fired in the previous cycle.
- Flush:
  - ST_WAIT returns to RUN and `st_commit_valid` is cleared next cycle.
  - Any commit in the flush cycle is ignored: `commit_ready = 0`.
  - A pending free and a pending AMT pulse are NOT dropped, because they belong to already-retired instructions.
- Reset: the FSM goes to RUN and every output register goes to 0.

## Timing
Reset values:
- `amt_we = 0`, `amt_rd_arch = 0`, `amt_pd = 0`.
- `free_valid = 0`, `free_pd = 0`.
- `st_commit_valid = 0`, `st_commit_rob_idx = 0`.
- `instret = 0`.
- `commit_ready` follows its combinational rule from the reset state.

Latencies:
- Commit fire to `amt_we`: exactly 1 cycle.
- Commit fire to `free_valid`: 1 cycle.
- Store at head to `st_commit_valid`: 1 cycle.
- Store throughput: at least 2 cycles per store.
- Non-store throughput: 1 per cycle while `free_ready = 1`.

Flush priority:
- `flush_valid` takes priority over `commit_fire` and over `st_commit_ack` in the same cycle. The ack is ignored and the store is not counted.
- Reset asserted mid-ST_WAIT aborts the handshake.

## Configuration
`COMMIT_INSTRET_EN`:
- Defined:
  - `instret` is a 64-bit counter that adds 1 per `commit_fire`.
  - It wraps modulo 2^64.
  - It is not cleared by flush.
- Undefined:
  - The counter logic is absent and `instret` is tied to 0.

## Test plan
- Writer, then back-to-back writers with `free_ready = 1`:
  - commit `rd_arch = 3`, `pd_new = 40`, `pd_old = 12`.
  - Required: next cycle `amt_we = 1`, `amt_rd_arch = 3`, `amt_pd = 40`, `free_valid = 1`, `free_pd = 12`.
  - Back-to-back writers retire one per cycle.
- Free-list backpressure:
  - hold `free_ready = 0` for 3 cycles while a pending free exists.
  - Required: `commit_ready = 0` for all 3 cycles, `free_pd` is stable, and commit resumes on the cycle `free_ready` rises.
- Store handshake:
  - store at idx 5, with ack 4 cycles after request.
  - Required: `st_commit_valid = 1` with idx 5 throughout; `commit_ready = 1` only in the ack cycle; back in RUN next cycle; `instret` increments once.
- `rd_arch = 0` with `uses_rd = 1`:
  - Required: no `amt_we`, no `free_valid`, `instret` still increments.
- Flush during ST_WAIT, and in the same cycle as `st_commit_ack`:
  - Required: the ack is ignored, `st_commit_valid = 0` next cycle, and no commit or count occurs.
  - A pending free from the prior cycle still completes.
- `instret` wrap and reset:
  - preload `instret` near 2^64-1 by force, then perform 2 commits. Required: 2^64-1 then 0.
  - assert `rst` mid-stream. Required: all outputs 0 the next cycle.
